multichannel_sample_buffer: RTL and testbench
=============================================

# multichannel_sample_buffer

Parametrised multi-channel sample history buffer. Each channel holds the most recent DEPTH samples of SAMPLE_WIDTH bits in its own ring buffer, with a random-access read port indexed newest-first. It sits between the input sampling front end (`ui_in` capture) and the processing/output logic inside the TinyTapeout top wrapper. It adds three things a fixed shift-register buffer lacks: per-channel fill tracking, an overwrite/stop-when-full mode and per-channel clear.

## Interface
Parameters:
- NUM_CHANNELS, 14: number of independent channels (≥1).
- SAMPLE_WIDTH, 8: bits per sample.
- DEPTH, 10: samples retained per channel (≥2).
- Derived widths:
  - CH_W = $clog2(NUM_CHANNELS), minimum 1.
  - IDX_W = $clog2(DEPTH).
  - CNT_W = $clog2(DEPTH+1).
  - SUM_W = SAMPLE_WIDTH + CNT_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; when low, writes, reads and clears are ignored and state holds.
- overwrite  in  1  1 = ring mode (a full channel drops its oldest sample); 0 = stop-when-full (new sample dropped).
- wr_valid  in  1  write strobe.
- wr_ch  in  CH_W  target channel for the write.
- wr_data  in  SAMPLE_WIDTH  sample value.
- clr_valid  in  1  clear strobe.
- clr_ch  in  CH_W  channel to clear.
- rd_req  in  1  read strobe.
- rd_ch  in  CH_W  channel to read.
- rd_idx  in  IDX_W  sample age; 0 = newest.
- rd_valid  out  1  pulses 1 cycle after rd_req.
- rd_data  out  SAMPLE_WIDTH  requested sample.
- rd_err  out  1  with rd_valid: the index or channel was out of range.
- rd_count  out  CNT_W  fill count of rd_ch, sampled with the read.
- rd_sum  out  SUM_W  running sum of rd_ch (see Configuration).
- overflow  out  NUM_CHANNELS  sticky per-channel flag: a sample was dropped or evicted.

## Operation
- Per-channel state:
  - wr_ptr (IDX_W), wraps DEPTH-1 → 0.
  - count (CNT_W), saturates at DEPTH.
  - DEPTH×SAMPLE_WIDTH storage.
  - overflow bit.
- Write (ena & wr_valid & wr_ch < NUM_CHANNELS):
  - count < DEPTH: store at wr_ptr, advance wr_ptr, count+1.
  - count == DEPTH & overwrite=1: store at wr_ptr (oldest slot), advance wr_ptr, count unchanged, set overflow.
  - count == DEPTH & overwrite=0: discard sample, set overflow.
  - wr_ch ≥ NUM_CHANNELS: write ignored, no flag.
- Clear (ena & clr_valid, in-range): wr_ptr=0, count=0, overflow=0. Storage contents are not zeroed.
- Read (ena & rd_req):
  - Physical slot = (wr_ptr − 1 − rd_idx) mod DEPTH.
  - rd_idx ≥ count or rd_ch out of range: rd_data=0, rd_err=1, rd_count=0 for an out-of-range channel.
- Simultaneous events:
  - Clear and write to the same channel: clear wins, the write is dropped.
  - Read and write to the same channel: the read returns pre-write state.
  - Read and clear to the same channel: the read returns pre-clear state.
- Writes to different channels never interact. Exactly one write per cycle.

## Timing
- Write/clear: state updates on the same rising edge as the strobe.
- Read latency is 1 cycle. rd_valid is high for exactly one cycle per accepted rd_req. Back-to-back reads are allowed every cycle.
- rd_data, rd_err, rd_count and rd_sum are registered and hold their value until the next accepted read.
- Reset (asynchronous, immediate) values:
  - rd_valid=0, rd_data=0, rd_err=0, rd_count=0, rd_sum=0, overflow=0.
  - All wr_ptr=0, all count=0.
  - Storage is not reset.
- Reset asserted mid-read: no rd_valid after reset release.
- ena low drops any strobe presented in that cycle; an in-flight rd_valid still completes.

## Configuration
- MULTICHANNEL_SAMPLE_BUFFER_SUM_EN defined:
  - Each channel keeps a SUM_W running sum of its buffered samples.
  - Append adds wr_data. Ring eviction adds wr_data and subtracts the evicted sample in the same cycle. Clear zeroes the sum.
  - rd_sum returns the sum of rd_ch with read latency 1.
- Not defined: no sum registers, rd_sum tied to 0.

## Structure
- Shared package `sample_buffer_pkg`: width helper functions (CH_W/IDX_W/CNT_W/SUM_W derivation) and the slot-index wrap function.
- Sub-module `sample_ring`: one channel's storage, pointer, count, overflow and optional sum. Instantiated NUM_CHANNELS times via generate.
- The top level holds the write/clear decode and the registered read mux.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 to ch 3; read idx 0/1/2 → 0x33/0x22/0x11, rd_count=3, rd_err=0; idx 3 → rd_data=0, rd_err=1.
- overwrite=1: write 1..12 to ch 0 (DEPTH=10); idx 0 → 12, idx 9 → 3, count=10, overflow[0]=1, rd_sum=75 with SUM_EN.
- overwrite=0: write 1..12 to ch 0; idx 0 → 10, idx 9 → 1, overflow[0]=1, other overflow bits 0.
- Same cycle: write 0xAA and clear ch 5 → count 0, read idx 0 gives rd_err=1. Read and write ch 2 together → read returns the old newest value.
- wr_ch=15 (out of range) → no state change. rd_ch=14 → rd_err=1, rd_count=0.
- Assert rst_n low mid-stream while a read is pending → outputs 0 immediately, no rd_valid. Prior data is unreadable (count=0).

Source files
------------

// File: rtl/multichannel_sample_buffer_pkg.sv
// Shared width helpers and ring slot arithmetic for the multichannel sample buffer.
// The optional running-sum feature is enabled with MULTICHANNEL_SAMPLE_BUFFER_SUM_EN.
package sample_buffer_pkg;

  // Channel select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int sum_w(input int sw, input int depth);
    return sw + $clog2(depth + 1);
  endfunction

  // Physical slot of the sample aged idx: (ptr - 1 - idx) mod depth.
  // ptr < depth and idx < depth keep the sum below 2*depth, so one
  // conditional subtract replaces a modulo. Out-of-range ages map to 0;
  // the caller flags those as errors.
  function automatic int wrap_slot(input int ptr, input int idx, input int depth);
    int s;
    if (idx >= depth) return 0;
    s = ptr + depth - 1 - idx;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/multichannel_sample_buffer_sample_ring.sv
// One channel of sample history: ring storage, write pointer, fill count,
// sticky overflow and, with MULTICHANNEL_SAMPLE_BUFFER_SUM_EN, a running sum.
module sample_ring
  import sample_buffer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 10,
  localparam int IDX_W       = idx_w(DEPTH),
  localparam int CNT_W       = cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic                    overwrite,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  logic                    clr_en,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]        count,
  output logic                    overflow
`ifdef MULTICHANNEL_SAMPLE_BUFFER_SUM_EN
  ,
  output logic [sum_w(SAMPLE_WIDTH, DEPTH)-1:0] sum
`endif
);

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]        wr_ptr;
  logic [IDX_W-1:0]        rd_slot;
  logic                    full;
  logic                    store;

  assign full  = (count == CNT_W'(DEPTH));
  // Clear beats a same-cycle write; a full channel only stores in ring mode.
  assign store = wr_en && !clr_en && (!full || overwrite);

  assign rd_slot = IDX_W'(wrap_slot(int'(wr_ptr), int'(rd_idx), DEPTH));
  assign rd_data = mem[rd_slot];

  // Sample storage; deliberately not reset, a clear only rewinds the pointer.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= wr_data;
  end

  // Pointer, fill count and sticky overflow bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr_en) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      if (store) wr_ptr <= (wr_ptr == IDX_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
      else       overflow <= 1'b1;
    end
  end

`ifdef MULTICHANNEL_SAMPLE_BUFFER_SUM_EN
  localparam int SUM_W = sum_w(SAMPLE_WIDTH, DEPTH);

  // Running sum; on eviction the oldest sample sits at wr_ptr and leaves as the new one lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sum <= '0;
    else if (clr_en) sum <= '0;
    else if (store)  sum <= full ? sum + SUM_W'(wr_data) - SUM_W'(mem[wr_ptr])
                                 : sum + SUM_W'(wr_data);
  end
`endif

endmodule

// File: rtl/multichannel_sample_buffer.sv
// Multi-channel sample history buffer: write/clear decode into per-channel
// rings and a registered, 1-cycle-latency random-access read port.
// Optional running sum per channel: define MULTICHANNEL_SAMPLE_BUFFER_SUM_EN.
module multichannel_sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int NUM_CHANNELS = 14,
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 10,
  localparam int CH_W        = ch_w(NUM_CHANNELS),
  localparam int IDX_W       = idx_w(DEPTH),
  localparam int CNT_W       = cnt_w(DEPTH),
  localparam int SUM_W       = sum_w(SAMPLE_WIDTH, DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    overwrite,
  input  logic                    wr_valid,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  logic                    clr_valid,
  input  logic [CH_W-1:0]         clr_ch,
  input  logic                    rd_req,
  input  logic [CH_W-1:0]         rd_ch,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic                    rd_valid,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_err,
  output logic [CNT_W-1:0]        rd_count,
  output logic [SUM_W-1:0]        rd_sum,
  output logic [NUM_CHANNELS-1:0] overflow
);

  typedef struct packed {
    logic                    err;
    logic [SAMPLE_WIDTH-1:0] data;
    logic [CNT_W-1:0]        count;
  } rd_rsp_t;

  localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] ch_data;
  logic [NUM_CHANNELS-1:0][CNT_W-1:0]        ch_count;
  logic [1:0]                                vld_pipe;
  logic                                      rd_ch_ok;
  logic [CH_W-1:0]                           rd_sel;
  rd_rsp_t                                   rsp_d, rsp_q;

`ifdef MULTICHANNEL_SAMPLE_BUFFER_SUM_EN
  logic [NUM_CHANNELS-1:0][SUM_W-1:0]        ch_sum;
`endif

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    sample_ring #(
      .SAMPLE_WIDTH(SAMPLE_WIDTH),
      .DEPTH       (DEPTH)
    ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (ena && wr_valid && (wr_ch == CH_W'(i))),
      .overwrite(overwrite),
      .wr_data  (wr_data),
      .clr_en   (ena && clr_valid && (clr_ch == CH_W'(i))),
      .rd_idx   (rd_idx),
      .rd_data  (ch_data[i]),
      .count    (ch_count[i]),
      .overflow (overflow[i])
`ifdef MULTICHANNEL_SAMPLE_BUFFER_SUM_EN
      ,
      .sum      (ch_sum[i])
`endif
    );
  end

  // Out-of-range channels steer the mux to channel 0 so indexing stays in bounds.
  assign rd_ch_ok    = ({1'b0, rd_ch} < NCH);
  assign rd_sel      = rd_ch_ok ? rd_ch : '0;
  assign vld_pipe[0] = ena && rd_req;

  // Read response from pre-edge state, so same-cycle writes/clears are not visible.
  always_comb begin
    rsp_d     = '0;
    rsp_d.err = 1'b1;
    if (rd_ch_ok) begin
      rsp_d.count = ch_count[rd_sel];
      if (CNT_W'(rd_idx) < ch_count[rd_sel]) begin
        rsp_d.err  = 1'b0;
        rsp_d.data = ch_data[rd_sel];
      end
    end
  end

  // Read valid pulse and response hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      rsp_q       <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) rsp_q <= rsp_d;
    end
  end

`ifdef MULTICHANNEL_SAMPLE_BUFFER_SUM_EN
  // Sum of the read channel, captured alongside the read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rd_sum <= '0;
    else if (vld_pipe[0]) rd_sum <= rd_ch_ok ? ch_sum[rd_sel] : '0;
  end
`else
  assign rd_sum = '0;
`endif

  assign rd_valid = vld_pipe[1];
  assign rd_data  = rsp_q.data;
  assign rd_err   = rsp_q.err;
  assign rd_count = rsp_q.count;

endmodule

// File: tb/tb_multichannel_sample_buffer.sv
// Scoreboard bench for multichannel_sample_buffer: a queue-per-channel model
// predicts each read and the overflow flags; a negedge monitor checks them.
module tb_multichannel_sample_buffer;
  localparam int NCH = 14, SW = 8, DEPTH = 10;
  localparam int CH_W = 4, IDX_W = 4, CNT_W = 4, SUM_W = 12;

  logic             clk = 0, rst_n = 0, ena = 0, overwrite = 0;
  logic             wr_valid = 0, clr_valid = 0, rd_req = 0;
  logic [CH_W-1:0]  wr_ch = 0, clr_ch = 0, rd_ch = 0;
  logic [SW-1:0]    wr_data = 0;
  logic [IDX_W-1:0] rd_idx = 0;
  logic             rd_valid, rd_err;
  logic [SW-1:0]    rd_data;
  logic [CNT_W-1:0] rd_count;
  logic [SUM_W-1:0] rd_sum;
  logic [NCH-1:0]   overflow;

  multichannel_sample_buffer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .overwrite(overwrite),
    .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_data(wr_data),
    .clr_valid(clr_valid), .clr_ch(clr_ch),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .rd_count(rd_count), .rd_sum(rd_sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0]    data;
    logic             err;
    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] sum;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [SW-1:0] mq[NCH][$];   // newest sample at the back
  logic [NCH-1:0] movf = '0;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [SUM_W-1:0] qsum(input int ch);
    logic [SUM_W-1:0] s = '0;
    for (int k = 0; k < mq[ch].size(); k++) s += SUM_W'(mq[ch][k]);
    return s;
  endfunction

  // Monitor: flags every cycle, and every read response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("overflow", 32'(overflow), 32'(movf));
      if (rd_valid) begin
        if (sb.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("rd_data",  32'(rd_data),  32'(mon_e.data));
          chk("rd_err",   32'(rd_err),   32'(mon_e.err));
          chk("rd_count", 32'(rd_count), 32'(mon_e.count));
          chk("rd_sum",   32'(rd_sum),   32'(mon_e.sum));
        end
      end
    end
  end

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit en, input bit ow, input bit we, input int wch,
                      input int wd, input bit ce, input int cch,
                      input bit re, input int rch, input int ridx);
    exp_t e;
    ena = en; overwrite = ow;
    wr_valid = we;  wr_ch = CH_W'(wch); wr_data = SW'(wd);
    clr_valid = ce; clr_ch = CH_W'(cch);
    rd_req = re;    rd_ch = CH_W'(rch); rd_idx = IDX_W'(ridx);
    if (en && re) begin
      e.data = '0; e.err = 1'b1; e.count = '0; e.sum = '0;
      if (rch < NCH) begin
        e.count = CNT_W'(mq[rch].size());
`ifdef MULTICHANNEL_SAMPLE_BUFFER_SUM_EN
        e.sum = qsum(rch);
`endif
        if (ridx < mq[rch].size()) begin
          e.err  = 1'b0;
          e.data = mq[rch][mq[rch].size() - 1 - ridx];
        end
      end
      sb.push_back(e);
    end
    @(posedge clk);
    if (en && ce && cch < NCH) begin
      mq[cch] = {};
      movf[cch] = 1'b0;
    end
    if (en && we && wch < NCH && !(ce && cch == wch)) begin
      if (mq[wch].size() < DEPTH) mq[wch].push_back(SW'(wd));
      else begin
        movf[wch] = 1'b1;
        if (ow) begin
          void'(mq[wch].pop_front());
          mq[wch].push_back(SW'(wd));
        end
      end
    end
    #1;
    wr_valid = 0; clr_valid = 0; rd_req = 0;
  endtask

  task automatic wr(input int ch, input int d, input bit ow);
    step(1, ow, 1, ch, d, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int ch, input int idx);
    step(1, 0, 0, 0, 0, 0, 0, 1, ch, idx);
  endtask

  task automatic model_reset();
    sb = {};
    for (int c = 0; c < NCH; c++) mq[c] = {};
    movf = '0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_data"},  32'(rd_data),  0);
    chk({tag, "_rd_err"},   32'(rd_err),   0);
    chk({tag, "_rd_count"}, 32'(rd_count), 0);
    chk({tag, "_rd_sum"},   32'(rd_sum),   0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    #1 chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // basic append and newest-first reads, plus one past the fill level
    wr(3, 'h11, 0); wr(3, 'h22, 0); wr(3, 'h33, 0);
    for (int i = 0; i < 4; i++) rd(3, i);

    // ring mode on a full channel
    for (int v = 1; v <= 12; v++) wr(0, v, 1);
    rd(0, 0); rd(0, 9); rd(0, 10);

    // stop-when-full mode after a clear
    step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int v = 1; v <= 12; v++) wr(0, v, 0);
    rd(0, 0); rd(0, 9);

    // clear and write to the same channel: clear wins
    wr(5, 'h01, 0);
    step(1, 0, 1, 5, 'hAA, 1, 5, 0, 0, 0);
    rd(5, 0);

    // read and write to the same channel: read sees the old newest
    wr(2, 'h44, 0);
    step(1, 0, 1, 2, 'h55, 0, 0, 1, 2, 0);
    rd(2, 0); rd(2, 1);

    // read and clear to the same channel: read sees pre-clear state
    step(1, 0, 0, 0, 0, 1, 2, 1, 2, 0);
    rd(2, 0);

    // out-of-range channels, ena low, and the last channel
    wr(15, 'h99, 0); wr(14, 'h98, 0);
    rd(14, 0); rd(15, 0); rd(13, 0);
    step(0, 0, 1, 4, 'h77, 0, 0, 1, 4, 0);
    rd(4, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 255),
           $urandom_range(0, 15) == 0, $urandom_range(0, 15),
           $urandom_range(0, 1) != 0, $urandom_range(0, 15), $urandom_range(0, 15));

    // reset lands while a read response is being presented
    wr(3, 'h5A, 0);
    rd(3, 0);
    rst_n = 0;
    model_reset();
    #1 chk_zero_outputs("midreset");
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rd(3, 0);

    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
